ofs_plat_local_mem_axi_rsp_merge: RTL
=====================================

Name: ofs_plat_local_mem_axi_rsp_merge

Overview:
- Response-side companion to the PIM burst splitter.
- Sits on the B or R response path between the FIU local-memory AXI port and the AFU.
- Consumes FIU responses tagged with the NO_REPLY user flag and folds their status into a per-ID accumulator.
- Emits exactly one AFU-visible response per original AFU burst; that response carries the worst-case status of all its FIU segments.

Parameters:
- ID_WIDTH, 4, width of bid/rid; one accumulator per ID value (2**ID_WIDTH entries).
- USER_WIDTH, 8, width of the user field; must be >= 1.
- NO_REPLY_BIT, 0, user bit index of the NO_REPLY flag (matches the flag enumeration value).
- SEG_CNT_WIDTH, 4, width of the per-ID squashed-segment counter.
- MERGE_RESP, 1, mode select:
  - 1: fold squashed status into the final response.
  - 0: discard squashed status (legacy squash-only behaviour).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  FIU response valid
- in_ready  out  1  FIU response ready
- in_id  in  ID_WIDTH  FIU response ID
- in_resp  in  2  AXI response code
- in_user  in  USER_WIDTH  FIU response user bits
- out_valid  out  1  AFU response valid
- out_ready  in  1  AFU response ready
- out_id  out  ID_WIDTH  merged response ID
- out_resp  out  2  merged response code
- out_user  out  USER_WIDTH  in_user of the final segment, with NO_REPLY_BIT forced to 0
- out_seg_cnt  out  SEG_CNT_WIDTH+1  total segments merged, including the final one
- err_overflow  out  1  sticky; set when a segment counter saturates

Behaviour:
- Reset values: out_valid=0, out_id=0, out_resp=0, out_user=0, out_seg_cnt=0, err_overflow=0. All accumulators cleared (resp=EXOKAY-neutral, cnt=0, busy=0).
- Reset mid-operation discards every partial accumulation and any held output; the first response after reset starts a fresh accumulation.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - A beat is accepted when in_valid && in_ready.
  - The output register holds all fields stable while out_valid && !out_ready.
- Severity rank, highest first: DECERR(3) > SLVERR(2) > OKAY(0) > EXOKAY(1). merge(a,b) returns the higher-ranked code.
- Accepted beat with in_user[NO_REPLY_BIT]=1 (squashed):
  - no output produced;
  - acc_resp[id] <= MERGE_RESP ? merge(acc_resp[id], in_resp) : acc_resp[id];
  - acc_cnt[id] increments, saturating at all-ones; saturation sets err_overflow.
  - busy[id] <= 1.
- Accepted beat with NO_REPLY=0 (final):
  - output register loads next cycle (latency 1): out_id=in_id; out_resp=busy ? merge(acc_resp, in_resp) : in_resp (merge applied only when MERGE_RESP=1); out_seg_cnt=acc_cnt+1.
  - Accumulator for that ID cleared in the same edge.
- Squash followed by final for the same ID on back-to-back cycles: the final beat sees the updated accumulator. No extra bypass is needed because accumulator writes land at the accept edge.
- Different IDs interleave freely; accumulators are independent.
- Full throughput: one beat per cycle when out_ready is held high.
- Unaccepted beats (in_valid && !in_ready) leave all state unchanged.
- err_overflow clears only on reset.

Optional Feature:
- Macro: OFS_PLAT_LOCAL_MEM_AXI_RSP_MERGE_STATS_EN.
- Defined:
  - adds 32-bit output ports stat_squashed and stat_forwarded;
  - each wraps modulo 2**32, reset to 0;
  - stat_squashed increments per accepted squashed beat; stat_forwarded per out_valid && out_ready.
- Undefined: ports absent, no counters synthesised. Core behaviour is identical either way.

Test Plan:
- Reset then idle: out_valid=0, in_ready=1, err_overflow=0.
- ID 3, three beats: NO_REPLY OKAY, NO_REPLY SLVERR, final OKAY -> exactly one output, id=3, resp=SLVERR(2), seg_cnt=3, one cycle after the final accept.
- Same sequence with MERGE_RESP=0 -> single output, resp=OKAY, seg_cnt=3.
- Interleave ID1 squash DECERR, ID2 final EXOKAY, ID1 final OKAY, with out_ready low for 4 cycles -> in_ready=0 while held, outputs stable; delivered order ID2 EXOKAY seg_cnt=1, then ID1 DECERR seg_cnt=2.
- 16 squashes to ID0 with SEG_CNT_WIDTH=4 -> counter saturates at 15, err_overflow=1 and sticky; final yields seg_cnt=16.
- Reset asserted after 2 squashes on ID5, then a final on ID5 with resp OKAY -> resp=OKAY, seg_cnt=1. With STATS_EN defined, stat_squashed=0 after reset and stat_forwarded=1.

Source files
------------

// File: rtl/ofs_plat_local_mem_axi_rsp_merge.sv
// Folds NO_REPLY-squashed AXI B/R responses into per-ID accumulators and emits one merged response per burst.
// Optional statistics counters are enabled by defining OFS_PLAT_LOCAL_MEM_AXI_RSP_MERGE_STATS_EN.
module ofs_plat_local_mem_axi_rsp_merge #(
  parameter int ID_WIDTH      = 4,
  parameter int USER_WIDTH    = 8,
  parameter int NO_REPLY_BIT  = 0,
  parameter int SEG_CNT_WIDTH = 4,
  parameter int MERGE_RESP    = 1
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ID_WIDTH-1:0]      in_id,
  input  logic [1:0]               in_resp,
  input  logic [USER_WIDTH-1:0]    in_user,

  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ID_WIDTH-1:0]      out_id,
  output logic [1:0]               out_resp,
  output logic [USER_WIDTH-1:0]    out_user,
  output logic [SEG_CNT_WIDTH:0]   out_seg_cnt,
  output logic                     err_overflow
`ifdef OFS_PLAT_LOCAL_MEM_AXI_RSP_MERGE_STATS_EN
  ,
  output logic [31:0]              stat_squashed,
  output logic [31:0]              stat_forwarded
`endif
);

  localparam int NUM_IDS = 1 << ID_WIDTH;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [SEG_CNT_WIDTH-1:0] CNT_MAX = '1;

  // EXOKAY is the lowest severity, so it is the neutral element of the merge.
  function automatic logic [1:0] resp_rank(input logic [1:0] r);
    case (r)
      2'd1:    return 2'd0;
      2'd0:    return 2'd1;
      default: return r;
    endcase
  endfunction

  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    return (resp_rank(b) > resp_rank(a)) ? b : a;
  endfunction

  function automatic logic [SEG_CNT_WIDTH-1:0] cnt_sat_inc(input logic [SEG_CNT_WIDTH-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  logic [1:0]               acc_resp [NUM_IDS];
  logic [SEG_CNT_WIDTH-1:0] acc_cnt  [NUM_IDS];
  logic [NUM_IDS-1:0]       acc_busy;

  logic                     accept_p0;
  logic                     squash_p0;
  logic [1:0]               cur_resp_p0;
  logic [SEG_CNT_WIDTH-1:0] cur_cnt_p0;
  logic                     cur_busy_p0;
  logic [1:0]               sq_resp_p0;
  logic [1:0]               fin_resp_p0;
  logic [USER_WIDTH-1:0]    fin_user_p0;
  logic [SEG_CNT_WIDTH:0]   fin_cnt_p0;

  // Stage p0: accept decision and accumulator lookup for the incoming beat.
  assign in_ready    = !out_valid || out_ready;
  assign accept_p0   = in_valid && in_ready;
  assign squash_p0   = in_user[NO_REPLY_BIT];
  assign cur_resp_p0 = acc_resp[in_id];
  assign cur_cnt_p0  = acc_cnt[in_id];
  assign cur_busy_p0 = acc_busy[in_id];
  assign sq_resp_p0  = (MERGE_RESP != 0) ? resp_merge(cur_resp_p0, in_resp) : cur_resp_p0;
  assign fin_cnt_p0  = {1'b0, cur_cnt_p0} + {{SEG_CNT_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    fin_resp_p0 = in_resp;
    if ((MERGE_RESP != 0) && cur_busy_p0)
      fin_resp_p0 = resp_merge(cur_resp_p0, in_resp);
  end

  always_comb begin
    fin_user_p0               = in_user;
    fin_user_p0[NO_REPLY_BIT] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_IDS; i++) begin
        acc_resp[i] <= RESP_EXOKAY;
        acc_cnt[i]  <= '0;
      end
      acc_busy <= '0;
    end else if (accept_p0) begin
      if (squash_p0) begin
        acc_resp[in_id] <= sq_resp_p0;
        acc_cnt[in_id]  <= cnt_sat_inc(cur_cnt_p0);
        acc_busy[in_id] <= 1'b1;
      end else begin
        acc_resp[in_id] <= RESP_EXOKAY;
        acc_cnt[in_id]  <= '0;
        acc_busy[in_id] <= 1'b0;
      end
    end
  end

  // A squash that arrives with the counter already full loses a count.
  always_ff @(posedge clk) begin
    if (reset)
      err_overflow <= 1'b0;
    else if (accept_p0 && squash_p0 && (cur_cnt_p0 == CNT_MAX))
      err_overflow <= 1'b1;
  end

  // Stage p1: output register, held while the AFU back-pressures.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_id      <= '0;
      out_resp    <= '0;
      out_user    <= '0;
      out_seg_cnt <= '0;
    end else if (accept_p0 && !squash_p0) begin
      out_valid   <= 1'b1;
      out_id      <= in_id;
      out_resp    <= fin_resp_p0;
      out_user    <= fin_user_p0;
      out_seg_cnt <= fin_cnt_p0;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

`ifdef OFS_PLAT_LOCAL_MEM_AXI_RSP_MERGE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_squashed  <= '0;
      stat_forwarded <= '0;
    end else begin
      if (accept_p0 && squash_p0)
        stat_squashed <= stat_squashed + 32'd1;
      if (out_valid && out_ready)
        stat_forwarded <= stat_forwarded + 32'd1;
    end
  end
`endif

endmodule
